// File: rtl/video_pkg.sv
// Shared types and constants for the video blitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package video_pkg;

  localparam int FB_COORD_W = 7;   // 128x128 word framebuffer
  localparam int FB_ADDR_W  = 15;  // word address into video memory

  typedef enum logic {
    BLIT_FILL = 1'b0,
    BLIT_COPY = 1'b1
  } blit_op_e;

  typedef struct packed {
    blit_op_e                op;
    logic [FB_ADDR_W-1:0]    base;
    logic [FB_COORD_W-1:0]   dst_x;
    logic [FB_COORD_W-1:0]   dst_y;
    logic [FB_COORD_W-1:0]   src_x;
    logic [FB_COORD_W-1:0]   src_y;
    logic [FB_COORD_W:0]     w;
    logic [FB_COORD_W:0]     h;
    logic [23:0]             color;
  } blit_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_COPY_RD,
    ST_COPY_WR,
    ST_DONE
  } blit_state_e;

  // Framebuffer word address: row-major {y,x} offset from base, wrapping.
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [FB_ADDR_W-1:0]  base,
                                                   input logic [FB_COORD_W-1:0] x,
                                                   input logic [FB_COORD_W-1:0] y);
    return base + FB_ADDR_W'({y, x});
  endfunction

endpackage

// File: rtl/video_blitter_if.sv
// Command channel and video memory port of the blitter.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready on the command side; the memory port never stalls.
//  blit_cmd_if : cmd_valid/cmd_ready handshake, command fields, busy, done
//  blit_mem_if : mem_en, mem_we, mem_addr, mem_write, mem_read
interface blit_cmd_if;
  logic                                  cmd_valid;
  logic                                  cmd_ready;
  video_pkg::blit_op_e                   cmd_op;
  logic [video_pkg::FB_ADDR_W-1:0]       cmd_base;
  logic [video_pkg::FB_COORD_W-1:0]      cmd_dst_x;
  logic [video_pkg::FB_COORD_W-1:0]      cmd_dst_y;
  logic [video_pkg::FB_COORD_W-1:0]      cmd_src_x;
  logic [video_pkg::FB_COORD_W-1:0]      cmd_src_y;
  logic [video_pkg::FB_COORD_W:0]        cmd_w;
  logic [video_pkg::FB_COORD_W:0]        cmd_h;
  logic [23:0]                           cmd_color;
  logic                                  busy;
  logic                                  done;

  modport master (
    output cmd_valid, cmd_op, cmd_base, cmd_dst_x, cmd_dst_y,
           cmd_src_x, cmd_src_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, busy, done
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_base, cmd_dst_x, cmd_dst_y,
           cmd_src_x, cmd_src_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, busy, done
  );
endinterface

interface blit_mem_if;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write;
  logic [31:0] mem_read;

  modport master (output mem_en, mem_we, mem_addr, mem_write, input mem_read);
  modport slave  (input mem_en, mem_we, mem_addr, mem_write, output mem_read);
endinterface

// File: rtl/blit_scan.sv
// Rectangle scan counter: walks (i,j) row-major, forward or reverse, and offsets by an origin.
// Latency: nxt_x/nxt_y are combinational (the position after this cycle's start/step); last is registered.
// Backpressure: advances only on step; holds otherwise.
//  start        : load origin/size/direction from the inputs, position = first pixel
//  step         : advance to the next pixel
//  nxt_x/nxt_y  : wrapped coordinate of the position the counter holds after this edge
//  last         : the currently held position is the final pixel of the rectangle
module blit_scan
  import video_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step,
  input  logic                  reverse,
  input  logic [FB_COORD_W-1:0] org_x,
  input  logic [FB_COORD_W-1:0] org_y,
  input  logic [FB_COORD_W:0]   w,
  input  logic [FB_COORD_W:0]   h,
  output logic [FB_COORD_W-1:0] nxt_x,
  output logic [FB_COORD_W-1:0] nxt_y,
  output logic                  last
);
  localparam int CW = FB_COORD_W;
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW:0]   D_ONE = (CW+1)'(1);

  logic [CW-1:0] i_q, j_q, wm1_q, hm1_q, org_x_q, org_y_q;
  logic          rev_q, last_q;

  logic [CW-1:0] wm1, hm1, ox, oy, i_n, j_n;
  logic          rev, fin;

  always_comb begin
    // On start the size/origin come straight from the command so the first
    // address can be registered on the accept edge.
    wm1 = start ? CW'(w - D_ONE) : wm1_q;
    hm1 = start ? CW'(h - D_ONE) : hm1_q;
    rev = start ? reverse : rev_q;
    ox  = start ? org_x : org_x_q;
    oy  = start ? org_y : org_y_q;
    i_n = i_q;
    j_n = j_q;
    if (start) begin
      i_n = rev ? wm1 : '0;
      j_n = rev ? hm1 : '0;
    end else if (step) begin
      if (!rev) begin
        if (i_q == wm1) begin
          i_n = '0;
          j_n = j_q + C_ONE;
        end else begin
          i_n = i_q + C_ONE;
        end
      end else begin
        if (i_q == '0) begin
          i_n = wm1;
          j_n = j_q - C_ONE;
        end else begin
          i_n = i_q - C_ONE;
        end
      end
    end
    fin   = rev ? ((i_n == '0) && (j_n == '0)) : ((i_n == wm1) && (j_n == hm1));
    nxt_x = ox + i_n;
    nxt_y = oy + j_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q     <= '0;
      j_q     <= '0;
      wm1_q   <= '0;
      hm1_q   <= '0;
      org_x_q <= '0;
      org_y_q <= '0;
      rev_q   <= 1'b0;
      last_q  <= 1'b0;
    end else if (start || step) begin
      i_q    <= i_n;
      j_q    <= j_n;
      last_q <= fin;
      if (start) begin
        wm1_q   <= wm1;
        hm1_q   <= hm1;
        rev_q   <= rev;
        org_x_q <= ox;
        org_y_q <= oy;
      end
    end
  end

  assign last = last_q;

endmodule

// File: rtl/video_blitter.sv
// Rectangle FILL/COPY engine mastering the video unit's memory port.
// Latency: FILL first write 1 cycle after accept, 1 word/cycle, done at T+w*h+1; COPY 2 cycles/pixel, done at T+2*w*h+1.
// Backpressure: one command at a time; cmd_ready low from accept until back in IDLE, no queueing.
//  clk, rst : clock (shared with video unit mem_clk), async active-high reset
//  cmd      : command handshake and fields, busy, done pulse
//  mem      : video memory port (read data valid the cycle after a read)
module video_blitter
  import video_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  blit_cmd_if.slave  cmd,
  blit_mem_if.master mem
);
  localparam int CW = FB_COORD_W;

  blit_cmd_t   cmd_in;
  blit_state_e state;

  logic                 ready_q, busy_q, done_q, en_q;
  logic [3:0]           we_q;
  logic [15:0]          addr_q;
  logic [31:0]          wdata_q;
  logic [FB_ADDR_W-1:0] base_q;

  logic                 accept, empty, rev_in, dst_step, src_step, dst_last, src_last;
  logic [CW-1:0]        dst_x_n, dst_y_n, src_x_n, src_y_n;
  logic [FB_ADDR_W-1:0] base_sel, dst_addr, src_addr;

  always_comb begin
    cmd_in.op    = cmd.cmd_op;
    cmd_in.base  = cmd.cmd_base;
    cmd_in.dst_x = cmd.cmd_dst_x;
    cmd_in.dst_y = cmd.cmd_dst_y;
    cmd_in.src_x = cmd.cmd_src_x;
    cmd_in.src_y = cmd.cmd_src_y;
    cmd_in.w     = cmd.cmd_w;
    cmd_in.h     = cmd.cmd_h;
    cmd_in.color = cmd.cmd_color;
  end

  assign accept = (state == ST_IDLE) && cmd.cmd_valid;
  assign empty  = (cmd_in.w == '0) || (cmd_in.h == '0);
  // Destination after source in scan order: walk backwards so overlapping
  // source pixels are read before they are overwritten.
  assign rev_in = (cmd_in.op == BLIT_COPY) &&
                  ({cmd_in.dst_y, cmd_in.dst_x} > {cmd_in.src_y, cmd_in.src_x});

  assign dst_step = ((state == ST_FILL) || (state == ST_COPY_WR)) && !dst_last;
  assign src_step = (state == ST_COPY_WR) && !src_last;

  blit_scan u_dst_scan (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .step    (dst_step),
    .reverse (rev_in),
    .org_x   (cmd_in.dst_x),
    .org_y   (cmd_in.dst_y),
    .w       (cmd_in.w),
    .h       (cmd_in.h),
    .nxt_x   (dst_x_n),
    .nxt_y   (dst_y_n),
    .last    (dst_last)
  );

  blit_scan u_src_scan (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .step    (src_step),
    .reverse (rev_in),
    .org_x   (cmd_in.src_x),
    .org_y   (cmd_in.src_y),
    .w       (cmd_in.w),
    .h       (cmd_in.h),
    .nxt_x   (src_x_n),
    .nxt_y   (src_y_n),
    .last    (src_last)
  );

  assign base_sel = (state == ST_IDLE) ? cmd_in.base : base_q;
  assign dst_addr = fb_addr(base_sel, dst_x_n, dst_y_n);
  assign src_addr = fb_addr(base_sel, src_x_n, src_y_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 4'h0;
      addr_q  <= '0;
      wdata_q <= '0;
      base_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd.cmd_valid) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            base_q  <= cmd_in.base;
            wdata_q <= {8'h00, cmd_in.color};
            if (empty) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else if (cmd_in.op == BLIT_FILL) begin
              state  <= ST_FILL;
              en_q   <= 1'b1;
              we_q   <= 4'hF;
              addr_q <= {1'b0, dst_addr};
            end else begin
              state  <= ST_COPY_RD;
              en_q   <= 1'b1;
              we_q   <= 4'h0;
              addr_q <= {1'b0, src_addr};
            end
          end
        end
        ST_FILL: begin
          if (dst_last) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
            en_q   <= 1'b0;
            we_q   <= 4'h0;
          end else begin
            addr_q <= {1'b0, dst_addr};
          end
        end
        ST_COPY_RD: begin
          // Destination scan is not stepping here, so dst_addr is the current pixel.
          state  <= ST_COPY_WR;
          we_q   <= 4'hF;
          addr_q <= {1'b0, dst_addr};
        end
        ST_COPY_WR: begin
          if (src_last) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
            en_q   <= 1'b0;
            we_q   <= 4'h0;
          end else begin
            state  <= ST_COPY_RD;
            we_q   <= 4'h0;
            addr_q <= {1'b0, src_addr};
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign cmd.busy      = busy_q;
  assign cmd.done      = done_q;
  assign mem.mem_en    = en_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  // Read data only arrives in the write cycle itself, so COPY writes forward it directly.
  assign mem.mem_write = (state == ST_COPY_WR) ? mem.mem_read : wdata_q;

endmodule

// File: tb/tb_video_blitter.sv
module tb_video_blitter;
  import video_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  blit_cmd_if cmd ();
  blit_mem_if mem ();

  video_blitter dut (
    .clk (clk),
    .rst (rst),
    .cmd (cmd),
    .mem (mem)
  );

  int vecs = 0;
  int errs = 0;

  // Video memory model: synchronous, read data valid the cycle after a read.
  logic [31:0] fbmem [0:32767];
  logic [31:0] rd_q;
  logic [15:0] wa_q [$];
  logic [31:0] wd_q [$];
  logic [3:0]  ww_q [$];
  int          en_cnt = 0;
  int          bit15_bad = 0;

  assign mem.mem_read = rd_q;

  always @(posedge clk) begin
    if (mem.mem_en) begin
      en_cnt++;
      if (mem.mem_addr[15]) bit15_bad++;
      if (mem.mem_we != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (mem.mem_we[b]) fbmem[mem.mem_addr[14:0]][8*b +: 8] = mem.mem_write[8*b +: 8];
        wa_q.push_back(mem.mem_addr);
        wd_q.push_back(mem.mem_write);
        ww_q.push_back(mem.mem_we);
      end else begin
        rd_q <= fbmem[mem.mem_addr[14:0]];
      end
    end
  end

  logic [15:0] exp_t1 [8] = '{16'h0182, 16'h0183, 16'h0184, 16'h0185,
                              16'h0202, 16'h0203, 16'h0204, 16'h0205};
  logic [15:0] exp_t2 [8] = '{16'h40FE, 16'h40FF, 16'h4080, 16'h4081,
                              16'h017E, 16'h017F, 16'h0100, 16'h0101};
  logic [31:0] exp_t3 [5] = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    ww_q.delete();
    en_cnt = 0;
  endtask

  task automatic issue(input blit_op_e op, input logic [14:0] base,
                       input logic [6:0] dx, input logic [6:0] dy,
                       input logic [6:0] sx, input logic [6:0] sy,
                       input logic [7:0] w, input logic [7:0] h,
                       input logic [23:0] color, input bit hold);
    cmd.cmd_op    = op;
    cmd.cmd_base  = base;
    cmd.cmd_dst_x = dx;
    cmd.cmd_dst_y = dy;
    cmd.cmd_src_x = sx;
    cmd.cmd_src_y = sy;
    cmd.cmd_w     = w;
    cmd.cmd_h     = h;
    cmd.cmd_color = color;
    cmd.cmd_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) cmd.cmd_valid = 1'b0;
  endtask

  // Returns k such that done is high in cycle T+k (k=1 is the cycle after the accept edge).
  task automatic wait_done(output int k);
    k = 1;
    while (cmd.done !== 1'b1 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  initial begin
    int k;
    int spurious;

    rst = 1'b1;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op    = BLIT_FILL;
    cmd.cmd_base  = '0;
    cmd.cmd_dst_x = '0;
    cmd.cmd_dst_y = '0;
    cmd.cmd_src_x = '0;
    cmd.cmd_src_y = '0;
    cmd.cmd_w     = '0;
    cmd.cmd_h     = '0;
    cmd.cmd_color = '0;
    @(posedge clk); #1;
    chk("rst_ready", {31'd0, cmd.cmd_ready}, 32'd1);
    chk("rst_busy",  {31'd0, cmd.busy}, 32'd0);
    chk("rst_done",  {31'd0, cmd.done}, 32'd0);
    chk("rst_en",    {31'd0, mem.mem_en}, 32'd0);
    chk("rst_we",    {28'd0, mem.mem_we}, 32'd0);
    chk("rst_addr",  {16'd0, mem.mem_addr}, 32'd0);
    chk("rst_wdata", mem.mem_write, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: basic FILL
    clear_log();
    issue(BLIT_FILL, 15'h0000, 7'd2, 7'd3, 7'd0, 7'd0, 8'd4, 8'd2, 24'h123456, 1'b0);
    wait_done(k);
    chk("t1_done_cycle", k, 32'd9);
    chk("t1_nwrites", wa_q.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_addr%0d", i), {16'd0, wa_q[i]}, {16'd0, exp_t1[i]});
      chk($sformatf("t1_data%0d", i), wd_q[i], 32'h0012_3456);
      chk($sformatf("t1_we%0d", i), {28'd0, ww_q[i]}, 32'hF);
    end
    @(posedge clk); #1;
    chk("t1_ready_back", {31'd0, cmd.cmd_ready}, 32'd1);

    // 2: FILL wrapping in x and y, nonzero base
    clear_log();
    issue(BLIT_FILL, 15'h0100, 7'd126, 7'd127, 7'd0, 7'd0, 8'd4, 8'd2, 24'hABCDEF, 1'b0);
    wait_done(k);
    chk("t2_done_cycle", k, 32'd9);
    chk("t2_nwrites", wa_q.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_addr%0d", i), {16'd0, wa_q[i]}, {16'd0, exp_t2[i]});
    chk("t2_bit15", bit15_bad, 32'd0);
    @(posedge clk); #1;

    // 3: overlapping COPY one pixel right -> reverse scan
    fbmem[0] = 32'd0;
    fbmem[1] = 32'd1;
    fbmem[2] = 32'd2;
    fbmem[3] = 32'd3;
    fbmem[4] = 32'hDEAD_BEEF;
    clear_log();
    issue(BLIT_COPY, 15'h0000, 7'd1, 7'd0, 7'd0, 7'd0, 8'd4, 8'd1, 24'h000000, 1'b0);
    wait_done(k);
    chk("t3_done_cycle", k, 32'd9);
    chk("t3_mem_cycles", en_cnt, 32'd8);
    chk("t3_first_waddr", {16'd0, wa_q[0]}, 32'd4);
    chk("t3_first_wdata", wd_q[0], 32'd3);
    for (int i = 0; i < 5; i++)
      chk($sformatf("t3_row%0d", i), fbmem[i], exp_t3[i]);
    @(posedge clk); #1;

    // 4: zero-width rectangle
    clear_log();
    issue(BLIT_FILL, 15'h0000, 7'd0, 7'd0, 7'd0, 7'd0, 8'd0, 8'd5, 24'h777777, 1'b0);
    chk("t4_done_t1", {31'd0, cmd.done}, 32'd1);
    chk("t4_ready_t1", {31'd0, cmd.cmd_ready}, 32'd0);
    @(posedge clk); #1;
    chk("t4_ready_t2", {31'd0, cmd.cmd_ready}, 32'd1);
    chk("t4_no_mem", en_cnt, 32'd0);

    // 5: reset in the middle of a COPY
    issue(BLIT_COPY, 15'h0000, 7'd0, 7'd20, 7'd0, 7'd10, 8'd4, 8'd2, 24'h000000, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t5_en",    {31'd0, mem.mem_en}, 32'd0);
    chk("t5_we",    {28'd0, mem.mem_we}, 32'd0);
    chk("t5_addr",  {16'd0, mem.mem_addr}, 32'd0);
    chk("t5_wdata", mem.mem_write, 32'd0);
    chk("t5_busy",  {31'd0, cmd.busy}, 32'd0);
    chk("t5_ready", {31'd0, cmd.cmd_ready}, 32'd1);
    chk("t5_done",  {31'd0, cmd.done}, 32'd0);
    #1 rst = 1'b0;
    spurious = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (cmd.done === 1'b1 || cmd.busy === 1'b1) spurious++;
    end
    chk("t5_quiet_after_rst", spurious, 32'd0);
    clear_log();
    issue(BLIT_FILL, 15'h0200, 7'd5, 7'd5, 7'd0, 7'd0, 8'd2, 8'd1, 24'h00FF00, 1'b0);
    wait_done(k);
    chk("t5_next_done", k, 32'd3);
    chk("t5_next_nwr", wa_q.size(), 32'd2);
    chk("t5_next_a0", {16'd0, wa_q[0]}, 32'h0485);
    chk("t5_next_a1", {16'd0, wa_q[1]}, 32'h0486);
    chk("t5_next_d0", wd_q[0], 32'h0000_FF00);
    @(posedge clk); #1;

    // 6: command held valid and changing while busy
    clear_log();
    issue(BLIT_FILL, 15'h0000, 7'd10, 7'd20, 7'd0, 7'd0, 8'd3, 8'd1, 24'h111111, 1'b1);
    for (int kk = 1; kk <= 3; kk++) begin
      chk($sformatf("t6_ready_k%0d", kk), {31'd0, cmd.cmd_ready}, 32'd0);
      cmd.cmd_color = 24'h222222 + 24'(kk);
      cmd.cmd_w     = 8'd7;
      cmd.cmd_dst_x = 7'(kk * 9);
      @(posedge clk); #1;
    end
    chk("t6_done_k4", {31'd0, cmd.done}, 32'd1);
    chk("t6_ready_k4", {31'd0, cmd.cmd_ready}, 32'd0);
    cmd.cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("t6_ready_idle", {31'd0, cmd.cmd_ready}, 32'd1);
    @(posedge clk); #1;
    chk("t6_nwrites", wa_q.size(), 32'd3);
    chk("t6_a0", {16'd0, wa_q[0]}, 32'h0A0A);
    chk("t6_a2", {16'd0, wa_q[2]}, 32'h0A0C);
    chk("t6_d2", wd_q[2], 32'h0011_1111);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
